// File: rtl/instr_encoder.sv
// Encodes operation requests into 32-bit MIPS-style instruction words and
// writes them sequentially into instruction memory with a valid/ack handshake.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] count,
  output logic        full,
  output logic        err
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [15:0] DEPTH_CNT = 16'(DEPTH);

  state_t      state, state_next;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        write_done;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (op_sel)
      4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    enc_word = {6'b100011, rs, rt, imm};
      4'd6:    enc_word = {6'b101011, rs, rt, imm};
      4'd7:    enc_word = {6'b000100, rs, rt, imm};
      4'd8:    enc_word = {6'b001101, rs, rt, imm};
      4'd9:    enc_word = {6'b001001, rs, rt, imm};
      4'd10:   enc_word = {6'b000010, target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign full       = (count == DEPTH_CNT);
  assign in_ready   = (state == IDLE) && !full;
  assign mem_we     = (state == WRITE);
  assign accept     = in_valid && in_ready;
  assign write_done = (state == WRITE) && mem_ack;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept && enc_legal) state_next = WRITE;
      WRITE: if (mem_ack)             state_next = IDLE;
    endcase
  end

  // count never exceeds DEPTH, so mem_addr is bounded by BASE_ADDR + 4*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && enc_legal)
        mem_wdata <= enc_word;
      if (accept && !enc_legal)
        err <= 1'b1;
      if (write_done) begin
        mem_addr <= mem_addr + 32'd4;
        count    <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH = 4, BASE_ADDR = 0).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] count;
  logic        full;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [15:0] i, input logic [25:0] t);
    op_sel = op; rs = a; rt = b; rd = c; imm = i; target = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=00000000", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=00000000", mem_wdata); end
    n_cmp++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_add();
    apply_reset();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL add_mem_we got=%b exp=1", mem_we); end
    n_cmp++; if (mem_wdata !== 32'h00221820) begin n_fail++; $display("FAIL add_wdata got=%h exp=00221820", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL add_addr got=%h exp=00000000", mem_addr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_write got=%b exp=0", in_ready); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL add_mem_we_after got=%b exp=0", mem_we); end
    n_cmp++; if (count !== 16'd1) begin n_fail++; $display("FAIL add_count got=%0d exp=1", count); end
    n_cmp++; if (mem_addr !== 32'h4) begin n_fail++; $display("FAIL add_addr_after got=%h exp=00000004", mem_addr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_encodings();
    vecs[0] = '{4'd5,  5'd29, 5'd8,  5'd0,  16'h0004, 26'd0,          32'h8FA80004};
    vecs[1] = '{4'd7,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'd0,          32'h1022FFFF};
    vecs[2] = '{4'd10, 5'd7,  5'd9,  5'd11, 16'h1234, 26'h0000010,    32'h08000010};
    vecs[3] = '{4'd6,  5'd2,  5'd3,  5'd0,  16'h0010, 26'd0,          32'hAC430010};
    vecs[4] = '{4'd8,  5'd0,  5'd9,  5'd0,  16'h00FF, 26'd0,          32'h340900FF};
    vecs[5] = '{4'd9,  5'd31, 5'd1,  5'd0,  16'h8000, 26'd0,          32'h27E18000};
    vecs[6] = '{4'd2,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,          32'h00221824};
    vecs[7] = '{4'd3,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,          32'h00221825};
    vecs[8] = '{4'd4,  5'd8,  5'd9,  5'd10, 16'h0000, 26'd0,          32'h0109502A};
    vecs[9] = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'd0,          32'h00853022};
    for (int i = 0; i < 10; i++) begin
      apply_reset();
      set_req(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b1 || mem_wdata !== vecs[i].exp)
        begin n_fail++; $display("FAIL enc_op%0d we=%b wdata=%h exp we=1 wdata=%h", vecs[i].op, mem_we, mem_wdata, vecs[i].exp); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0);
    in_valid = 1'b1;
    tick();
    set_req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h00221820 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold_cyc%0d we=%b addr=%h wdata=%h rdy=%b exp we=1 addr=00000000 wdata=00221820 rdy=0", i, mem_we, mem_addr, mem_wdata, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || count !== 16'd0) begin n_fail++; $display("FAIL bp_cyc6 we=%b count=%0d exp we=1 count=0", mem_we, count); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (count !== 16'd1) begin n_fail++; $display("FAIL bp_count got=%0d exp=1", count); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL bp_we_after got=%b exp=0", mem_we); end
  endtask

  task automatic test_illegal();
    apply_reset();
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%b exp=1", err); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (mem_we !== 1'b0 || count !== 16'd0 || mem_addr !== 32'h0 || in_ready !== 1'b1)
        begin n_fail++; $display("FAIL ill_nowrite_cyc%0d we=%b count=%0d addr=%h rdy=%b exp we=0 count=0 addr=00000000 rdy=1", i, mem_we, count, mem_addr, in_ready); end
      tick();
    end
    set_req(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00853022) begin n_fail++; $display("FAIL ill_sub we=%b wdata=%h exp we=1 wdata=00853022", mem_we, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (count !== 16'd1) begin n_fail++; $display("FAIL ill_sub_count got=%0d exp=1", count); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0);
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got=%b exp=1", k, in_ready); end
      tick();
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 32'(4 * k))
        begin n_fail++; $display("FAIL b2b_write_%0d we=%b addr=%h exp we=1 addr=%h", k, mem_we, mem_addr, 32'(4 * k)); end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 16'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", count); end
    tick();
    mem_ack = 1'b0;
    n_cmp++; if (count !== 16'd3 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_ack_ignored count=%0d we=%b exp count=3 we=0", count, mem_we); end
  endtask

  task automatic test_full();
    apply_reset();
    set_req(4'd9, 5'd1, 5'd1, 5'd0, 16'h0001, 26'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mem_ack  = 1'b1;
      tick();
      mem_ack = 1'b0;
    end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b exp=1", full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL full_addr got=%h exp=00000010", mem_addr); end
    n_cmp++; if (count !== 16'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (mem_we !== 1'b0 || count !== 16'd4 || mem_addr !== 32'h10)
        begin n_fail++; $display("FAIL full_blocked_%0d we=%b count=%0d addr=%h exp we=0 count=4 addr=00000010", i, mem_we, count, mem_addr); end
    end
    in_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw_pre_we got=%b exp=1", mem_we); end
    rst     = 1'b1;
    mem_ack = 1'b1;
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_we got=%b exp=0", mem_we); end
    n_cmp++; if (count !== 16'd0) begin n_fail++; $display("FAIL rmw_count got=%0d exp=0", count); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmw_addr got=%h exp=00000000", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rmw_wdata got=%h exp=00000000", mem_wdata); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_in_ready got=%b exp=1", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1 || count !== 16'd0) begin n_fail++; $display("FAIL rmw_after rdy=%b count=%0d exp rdy=1 count=0", in_ready, count); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_encodings();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_full();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
